seg7_scanner: RTL and testbench

Multiplexed 8-digit seven-segment scanner, directly downstream of the register/memory display select stage. It takes the selected 32-bit word and shows it as eight hex digits on the board's common-anode display, one digit at a time. A digit prescaler drives the refresh rate. The word is snapshotted once per frame so a digit never tears mid-scan.

---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_scanner_if.sv | 14 +
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg7_scanner.sv | 101 ++++++++++
 tb/tb_seg7_scanner.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the eight-digit seven-segment scanner.
// Segment vectors are active-low and ordered a..g from bit 6 down to bit 0.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h7F;

  localparam seg_t HEX_SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seg7_scanner_if.sv
// Display-side signal bundle: the word to show in, and the multiplexed drive out.
interface seg7_scanner_if;

  logic [31:0] data;
  logic [7:0]  dp_sel;
  logic [6:0]  a2g;
  logic [7:0]  an;
  logic        dp;
  logic        frame;

  modport master (output data, dp_sel, input a2g, an, dp, frame);
  modport slave  (input data, dp_sel, output a2g, an, dp, frame);

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low segment pattern lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg7_scanner.sv
// Multiplexed 8-digit hex scanner with a once-per-frame snapshot of the input word.
// Optional leading-zero blanking is enabled by defining SEG7_BLANK_EN.
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int DIV = 100000
) (
  input  logic           clk,
  input  logic           clr,
  seg7_scanner_if.slave  bus
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]    dig_q, dig_d;
  logic [31:0]   snap_data_q, snap_data_d;
  logic [7:0]    snap_dp_q, snap_dp_d;
  logic          load_pend_q, load_pend_d;
  logic          loaded_q, loaded_d;
  logic [7:0]    an_q, an_d;
  seg_t          a2g_q, a2g_d;
  logic          dp_q, dp_d;
  logic          frame_q, frame_d;

  logic          tick;
  logic          load_now;
  logic [3:0]    cur_nib;
  seg_t          cur_seg;
  logic [NUM_DIGITS-1:0] blank_mask;

  assign tick     = (div_cnt_q == CW'(DIV - 1));
  // The wrap tick and the snapshot share an edge so digit 0 of a frame shows new data.
  assign load_now = load_pend_q | (tick & (dig_q == 3'd7));
  assign cur_nib  = snap_data_q[4*dig_q +: 4];

  seg7_hex_decode u_dec (
    .nib (cur_nib),
    .seg (cur_seg)
  );

  always_comb begin
    blank_mask = '0;
`ifdef SEG7_BLANK_EN
    for (int i = 1; i < NUM_DIGITS; i++) begin
      blank_mask[i] = ~|(snap_data_q >> (4 * i));
    end
`endif
  end

  always_comb begin
    div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
    dig_d       = tick ? dig_q + 3'd1 : dig_q;
    snap_data_d = load_now ? bus.data : snap_data_q;
    snap_dp_d   = load_now ? bus.dp_sel : snap_dp_q;
    load_pend_d = 1'b0;
    loaded_d    = load_now;
    frame_d     = loaded_q;
    an_d        = ~(8'b1 << dig_q);
    a2g_d       = cur_seg;
    dp_d        = ~snap_dp_q[dig_q];
    // Stay dark until the first snapshot exists; never flash the reset contents.
    if (load_pend_q || blank_mask[dig_q]) begin
      an_d  = 8'hFF;
      a2g_d = SEG_OFF;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      div_cnt_q   <= '0;
      dig_q       <= '0;
      snap_data_q <= '0;
      snap_dp_q   <= '0;
      load_pend_q <= 1'b1;
      loaded_q    <= 1'b0;
      an_q        <= 8'hFF;
      a2g_q       <= SEG_OFF;
      dp_q        <= 1'b1;
      frame_q     <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      dig_q       <= dig_d;
      snap_data_q <= snap_data_d;
      snap_dp_q   <= snap_dp_d;
      load_pend_q <= load_pend_d;
      loaded_q    <= loaded_d;
      an_q        <= an_d;
      a2g_q       <= a2g_d;
      dp_q        <= dp_d;
      frame_q     <= frame_d;
    end
  end

  assign bus.an    = an_q;
  assign bus.a2g   = a2g_q;
  assign bus.dp    = dp_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg7_scanner.sv
// Randomized bench for seg7_scanner against a cycle-count based display model.
// Build with SEG7_BLANK_EN defined to check the leading-zero blanking variant.
module tb_seg7_scanner;

  localparam int DIV   = 4;
  localparam int FRAME = 8 * DIV;
`ifdef SEG7_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  seg7_scanner_if bus ();

  seg7_scanner #(.DIV(DIV)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [6:0] hex_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Model: k counts edges since reset release; the display after edge k shows
  // digit floor((k-1)/DIV) mod 8 of the snapshot that existed before edge k.
  int          k = 0;
  int          last_frame = -1;
  logic [31:0] m_data = '0, disp_data = '0;
  logic [7:0]  m_dp = '0, disp_dp = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s k=%0d got=%h want=%h", tag, k, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [7:0] e_an;
    logic [6:0] e_a2g;
    logic       e_dp, e_frame;
    int         d;
    e_an = 8'hFF; e_a2g = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
    if (k >= 2) begin
      d = ((k - 1) / DIV) % 8;
      e_frame = (k == 2) || ((k - 1) % FRAME == 0);
      if (!(BLANK && d > 0 && (disp_data >> (4 * d)) == 0)) begin
        e_an  = ~(8'h01 << d);
        e_a2g = hex_tab[(disp_data >> (4 * d)) & 32'hF];
        e_dp  = ~disp_dp[d];
      end
    end
    chk("an", 32'(bus.an), 32'(e_an));
    chk("a2g", 32'(bus.a2g), 32'(e_a2g));
    chk("dp", 32'(bus.dp), 32'(e_dp));
    chk("frame", 32'(bus.frame), 32'(e_frame));
    if (bus.frame === 1'b1) begin
      if (last_frame > 2) chk("frame_period", 32'(k - last_frame), 32'(FRAME));
      last_frame = k;
    end
  endtask

  // Called at a negedge with inputs already driven; advances one clock.
  task automatic step(input logic nclr);
    clr = nclr;
    disp_data = m_data;
    disp_dp   = m_dp;
    if (!nclr) begin
      k = 0; m_data = '0; m_dp = '0; disp_data = '0; disp_dp = '0;
      last_frame = -1;
    end else begin
      k++;
      if (k == 1 || k % FRAME == 0) begin
        m_data = bus.data;
        m_dp   = bus.dp_sel;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        bus.data   = $urandom;
        bus.dp_sel = 8'($urandom);
      end
      step((rnd && $urandom_range(0, 59) == 0) ? 1'b0 : 1'b1);
    end
  endtask

  task automatic run_until_dig(input int d);
    int cur;
    cur = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cur = (k >= 2) ? ((k - 1) / DIV) % 8 : -1;
      if (cur == d) break;
      step(1'b1);
      cur = (k >= 2) ? ((k - 1) / DIV) % 8 : -1;
    end
    chk("dig_wait", 32'(cur), 32'(d));
  endtask

  initial begin
    bus.data   = '0;
    bus.dp_sel = '0;
    @(negedge clk);
    step(1'b0);
    step(1'b0);

    bus.data = 32'h1234ABCD;
    run(2, 1'b0);
    run_until_dig(3);
    bus.data = 32'hFFFFFFFF;
    run(FRAME + 2 * DIV, 1'b0);

    bus.dp_sel = 8'h04;
    run(2 * FRAME, 1'b0);

    bus.data   = 32'h00000A00;
    bus.dp_sel = 8'hFF;
    run(2 * FRAME, 1'b0);
    bus.data   = 32'h0;
    bus.dp_sel = 8'h00;
    run(2 * FRAME, 1'b0);

    bus.data = 32'hC0FFEE42;
    run_until_dig(5);
    step(1'b0);
    run(2 * FRAME, 1'b0);

    run(8 * FRAME, 1'b1);
    run(FRAME + 4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
